// File: rtl/wm_pkg.sv
// rtl/wm_pkg.sv - shared types, defaults and saturation helper for the watermark extractor
//
// Purpose: FSM state encoding, default parameter values and the overflow test
//          used when the signed quotient is clamped to the output width.
// Ports:   none (package).

package wm_pkg;

    localparam int DW_DEF        = 32;
    localparam int NUM_COEFF_DEF = 4096;
    localparam int CW_DEF        = 12;

    // Width of the magnitude fed to sat_needed; supports DW up to MAG_W-2.
    localparam int MAG_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        HOLD = 2'd2
    } wm_state_e;

    // True when sign/magnitude (neg, mag) does not fit a dw-bit two's-complement
    // value: positive limit is 2^(dw-1)-1, negative limit is -2^(dw-1).
    function automatic logic sat_needed(input logic             neg,
                                        input logic [MAG_W-1:0] mag,
                                        input int unsigned      dw);
        logic [MAG_W-1:0] lim;
        lim = MAG_W'(1) << (dw - 1);
        if (neg) begin
            return mag > lim;
        end
        return mag >= lim;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring unsigned divider, (DW+1)-bit dividend by DW-bit divisor
//
// Purpose: one quotient bit per cycle, MSB first, DW+1 iterations per operation.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start_i           load dividend/divisor and begin (ignored while busy)
//   dividend_i        unsigned dividend, DW+1 bits
//   divisor_i         unsigned divisor, DW bits
//   busy_o            iterations in progress
//   done_o            high during the final iteration cycle; quot_o is valid then
//   quot_o            quotient including the bit produced this cycle
//   dz_o              latched divisor is zero

module seq_divider #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [DW:0]   dividend_i,
    input  logic [DW-1:0] divisor_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [DW:0]   quot_o,
    output logic          dz_o
);

    localparam int ITER  = DW + 1;
    localparam int CNT_W = $clog2(ITER + 1);

    // dvd_q shifts the dividend out of its MSB while quotient bits enter at the LSB;
    // after ITER shifts it holds the full quotient.
    logic [DW:0]      dvd_q, dvd_d;
    logic [DW-1:0]    rem_q, rem_d;
    logic [DW-1:0]    dsr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [DW:0]      trial;
    logic             ge;
    logic             last;

    always_comb begin
        trial = {rem_q, dvd_q[DW]};
        ge    = trial >= {1'b0, dsr_q};
        // When ge holds the difference is below the divisor, so the low DW bits suffice.
        rem_d = ge ? (trial[DW-1:0] - dsr_q) : trial[DW-1:0];
        dvd_d = {dvd_q[DW-1:0], ge};
        last  = busy_q && (cnt_q == CNT_W'(ITER - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            dvd_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
        end else if (start_i && !busy_q) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            dvd_q  <= dividend_i;
            rem_q  <= '0;
            dsr_q  <= divisor_i;
        end else if (busy_q) begin
            dvd_q <= dvd_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = last;
    assign quot_o = dvd_d;
    assign dz_o   = (dsr_q == '0);

endmodule

// File: rtl/wm_extractor.sv
// rtl/wm_extractor.sv - recovers LL2 = (LLNEW - LL1) / alpha with frame indexing
//
// Purpose: handshake FSM, sign handling, saturation and per-frame coefficient counter
//          around the sequential divider.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input pair handshake
//   LLNEW, LL1               signed watermarked / cover coefficients
//   alpha                    unsigned embedding strength, sampled with the pair
//   out_valid/out_ready      result handshake
//   LL2                      signed recovered coefficient
//   coeff_index              position of LL2 within the frame
//   frame_done               pulse on the handshake of the last coefficient of a frame
//   div_err, sat_err         sticky alpha==0 / clamping flags

module wm_extractor
    import wm_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int NUM_COEFF = NUM_COEFF_DEF,
    parameter int CW        = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] LLNEW,
    input  logic [DW-1:0] LL1,
    input  logic [DW-1:0] alpha,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] LL2,
    output logic [CW-1:0] coeff_index,
    output logic          frame_done,
    output logic          div_err,
    output logic          sat_err
);

    localparam logic [DW-1:0] POS_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] NEG_MIN = {1'b1, {(DW-1){1'b0}}};

    wm_state_e     state_q, state_d;
    logic          neg_q;
    logic [DW-1:0] ll2_q;
    logic [CW-1:0] idx_q;
    logic          div_err_q;
    logic          sat_err_q;

    logic [DW:0]   diff;
    logic          neg_in;
    logic [DW:0]   mag_in;
    logic          capture;
    logic          out_hs;

    logic          div_busy;
    logic          div_done;
    logic [DW:0]   quot;
    logic          div_zero;

    logic          sat;
    logic [DW-1:0] q_signed;
    logic [DW-1:0] res;
    logic          sat_hit;

    // Difference at DW+1 bits cannot overflow; split into sign and magnitude.
    always_comb begin
        diff   = {LLNEW[DW-1], LLNEW} - {LL1[DW-1], LL1};
        neg_in = diff[DW];
        mag_in = neg_in ? (~diff + 1'b1) : diff;
    end

    assign capture = in_valid && (state_q == IDLE) && !div_busy;
    assign out_hs  = (state_q == HOLD) && out_ready;

    seq_divider #(
        .DW(DW)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start_i   (capture),
        .dividend_i(mag_in),
        .divisor_i (alpha),
        .busy_o    (div_busy),
        .done_o    (div_done),
        .quot_o    (quot),
        .dz_o      (div_zero)
    );

    // Final result is formed from the quotient bits of the last iteration, so it is
    // registered on the same edge that enters HOLD.
    always_comb begin
        sat      = sat_needed(neg_q, MAG_W'(quot), DW);
        q_signed = neg_q ? (~quot[DW-1:0] + 1'b1) : quot[DW-1:0];
        sat_hit  = !div_zero && sat;
        if (div_zero) begin
            res = '0;
        end else if (sat) begin
            res = neg_q ? NEG_MIN : POS_MAX;
        end else begin
            res = q_signed;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture)   state_d = DIV;
            DIV:     if (div_done)  state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == HOLD);
        frame_done = out_hs && (idx_q == CW'(NUM_COEFF - 1));
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q     <= 1'b0;
            ll2_q     <= '0;
            idx_q     <= '0;
            div_err_q <= 1'b0;
            sat_err_q <= 1'b0;
        end else begin
            if (capture) begin
                neg_q <= neg_in;
                if (alpha == '0) begin
                    div_err_q <= 1'b1;
                end
            end
            if ((state_q == DIV) && div_done) begin
                ll2_q <= res;
                if (sat_hit) begin
                    sat_err_q <= 1'b1;
                end
            end
            if (out_hs) begin
                idx_q <= (idx_q == CW'(NUM_COEFF - 1)) ? '0 : (idx_q + CW'(1));
            end
        end
    end

    assign LL2         = ll2_q;
    assign coeff_index = idx_q;
    assign div_err     = div_err_q;
    assign sat_err     = sat_err_q;

endmodule

// File: tb/tb_wm_extractor.sv
// tb/tb_wm_extractor.sv - directed self-checking bench for wm_extractor

module tb_wm_extractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] LLNEW;
    logic [31:0] LL1;
    logic [31:0] alpha;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] LL2;
    logic [11:0] coeff_index;
    logic        frame_done;
    logic        div_err;
    logic        sat_err;

    int n_cmp  = 0;
    int n_fail = 0;

    wm_extractor #(
        .DW(32),
        .NUM_COEFF(4),
        .CW(12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .LLNEW      (LLNEW),
        .LL1        (LL1),
        .alpha      (alpha),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .LL2        (LL2),
        .coeff_index(coeff_index),
        .frame_done (frame_done),
        .div_err    (div_err),
        .sat_err    (sat_err)
    );

    always #5 clk = ~clk;

    // Drives one pair, waits (bounded) for the result, records observations, then
    // completes the output handshake. Comparisons are made by the callers.
    task automatic run_pair(input  logic [31:0] a_new, input logic [31:0] a_old, input logic [31:0] a_alpha,
                            output int lat, output logic [31:0] r_ll2, output logic [11:0] r_idx,
                            output logic r_fd, output logic r_de, output logic r_se,
                            output logic r_rdy_after, output logic r_vld_after);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        in_valid = 1'b1; LLNEW = a_new; LL1 = a_old; alpha = a_alpha;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        r_ll2 = LL2; r_idx = coeff_index; r_de = div_err; r_se = sat_err;
        out_ready = 1'b1;
        #1;
        r_fd = frame_done;
        @(posedge clk); #1;
        out_ready = 1'b0;
        r_rdy_after = in_ready;
        r_vld_after = out_valid;
    endtask

    int          lat;
    logic [31:0] r_ll2;
    logic [11:0] r_idx;
    logic        r_fd, r_de, r_se, r_rdy, r_vld;

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        LLNEW = 32'd9; LL1 = 32'd1; alpha = 32'd2;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b1)     begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (LL2 !== 32'd0)         begin n_fail++; $display("FAIL reset_ll2: got %h want 0", LL2); end
        n_cmp++; if (coeff_index !== 12'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", coeff_index); end
        n_cmp++; if (frame_done !== 1'b0)   begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_cmp++; if ({div_err, sat_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {div_err, sat_err}); end
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1)     begin n_fail++; $display("FAIL reset_no_capture: in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        run_pair(32'd110, 32'd100, 32'd1, lat, r_ll2, r_idx, r_fd, r_de, r_se, r_rdy, r_vld);
        n_cmp++; if (lat !== 33)           begin n_fail++; $display("FAIL basic_latency: got %0d want 33", lat); end
        n_cmp++; if (r_ll2 !== 32'd10)     begin n_fail++; $display("FAIL basic_ll2: got %h want 0000000a", r_ll2); end
        n_cmp++; if (r_idx !== 12'd0)      begin n_fail++; $display("FAIL basic_idx: got %0d want 0", r_idx); end
        n_cmp++; if ({r_de, r_se} !== 2'b00) begin n_fail++; $display("FAIL basic_flags: got %b want 00", {r_de, r_se}); end
        n_cmp++; if (r_fd !== 1'b0)        begin n_fail++; $display("FAIL basic_frame_done: got %b want 0", r_fd); end
        n_cmp++; if ({r_rdy, r_vld} !== 2'b10) begin n_fail++; $display("FAIL basic_after_hs: got %b want 10", {r_rdy, r_vld}); end
    endtask

    task automatic test_negative();
        run_pair(32'd50, 32'd100, 32'd4, lat, r_ll2, r_idx, r_fd, r_de, r_se, r_rdy, r_vld);
        n_cmp++; if (r_ll2 !== 32'hFFFF_FFF4) begin n_fail++; $display("FAIL neg_trunc_ll2: got %h want fffffff4", r_ll2); end
        n_cmp++; if (r_idx !== 12'd1)      begin n_fail++; $display("FAIL neg_idx: got %0d want 1", r_idx); end
        n_cmp++; if (lat !== 33)           begin n_fail++; $display("FAIL neg_latency: got %0d want 33", lat); end
        run_pair(32'd107, 32'd100, 32'd2, lat, r_ll2, r_idx, r_fd, r_de, r_se, r_rdy, r_vld);
        n_cmp++; if (r_ll2 !== 32'd3)      begin n_fail++; $display("FAIL pos_trunc_ll2: got %h want 00000003", r_ll2); end
        n_cmp++; if (r_idx !== 12'd2)      begin n_fail++; $display("FAIL pos_trunc_idx: got %0d want 2", r_idx); end
    endtask

    task automatic test_backpressure();
        int w;
        logic second_seen;
        w = 0;
        in_valid = 1'b1; LLNEW = 32'd20; LL1 = 32'd0; alpha = 32'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && w < 100) begin
            @(posedge clk); #1; w++;
        end
        n_cmp++; if (w !== 33) begin n_fail++; $display("FAIL bp_latency: got %0d want 33", w); end
        in_valid = 1'b1; LLNEW = 32'd999; LL1 = 32'd0; alpha = 32'd1;
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (LL2 !== 32'd5)   begin n_fail++; $display("FAIL bp_ll2_stable[%0d]: got %h want 00000005", k, LL2); end
            n_cmp++; if ({in_ready, out_valid} !== 2'b01) begin n_fail++; $display("FAIL bp_ready_valid[%0d]: got %b want 01", k, {in_ready, out_valid}); end
            n_cmp++; if (coeff_index !== 12'd3) begin n_fail++; $display("FAIL bp_idx_stable[%0d]: got %0d want 3", k, coeff_index); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL bp_frame_done: got %b want 1", frame_done); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_after_hs: got %b want 10", {in_ready, out_valid}); end
        n_cmp++; if (coeff_index !== 12'd0) begin n_fail++; $display("FAIL bp_idx_wrap: got %0d want 0", coeff_index); end
        second_seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) second_seen = 1'b1;
        end
        n_cmp++; if (second_seen !== 1'b0) begin n_fail++; $display("FAIL bp_second_captured: got %b want 0", second_seen); end
    endtask

    task automatic test_frame_wrap();
        logic [11:0] exp_idx [5] = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd0};
        logic        exp_fd  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] exp_val;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_val = i;
            run_pair(32'd100 + 32'(3 * i), 32'd100, 32'd3, lat, r_ll2, r_idx, r_fd, r_de, r_se, r_rdy, r_vld);
            n_cmp++; if (r_idx !== exp_idx[i]) begin n_fail++; $display("FAIL wrap_idx[%0d]: got %0d want %0d", i, r_idx, exp_idx[i]); end
            n_cmp++; if (r_fd !== exp_fd[i])   begin n_fail++; $display("FAIL wrap_frame_done[%0d]: got %b want %b", i, r_fd, exp_fd[i]); end
            n_cmp++; if (r_ll2 !== exp_val)    begin n_fail++; $display("FAIL wrap_ll2[%0d]: got %h want %h", i, r_ll2, exp_val); end
        end
    endtask

    task automatic test_div_zero();
        run_pair(32'd5, 32'd1, 32'd0, lat, r_ll2, r_idx, r_fd, r_de, r_se, r_rdy, r_vld);
        n_cmp++; if (lat !== 33)           begin n_fail++; $display("FAIL dz_latency: got %0d want 33", lat); end
        n_cmp++; if (r_ll2 !== 32'd0)      begin n_fail++; $display("FAIL dz_ll2: got %h want 0", r_ll2); end
        n_cmp++; if ({r_de, r_se} !== 2'b10) begin n_fail++; $display("FAIL dz_flags: got %b want 10", {r_de, r_se}); end
        n_cmp++; if (r_idx !== 12'd1)      begin n_fail++; $display("FAIL dz_idx: got %0d want 1", r_idx); end
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if ({div_err, sat_err} !== 2'b00) begin n_fail++; $display("FAIL sat_reset_flags: got %b want 00", {div_err, sat_err}); end
        n_cmp++; if (coeff_index !== 12'd0) begin n_fail++; $display("FAIL sat_reset_idx: got %0d want 0", coeff_index); end
        run_pair(32'h8000_0000, 32'd0, 32'd1, lat, r_ll2, r_idx, r_fd, r_de, r_se, r_rdy, r_vld);
        n_cmp++; if (r_ll2 !== 32'h8000_0000) begin n_fail++; $display("FAIL sat_min_exact_ll2: got %h want 80000000", r_ll2); end
        n_cmp++; if (r_se !== 1'b0)        begin n_fail++; $display("FAIL sat_min_exact_flag: got %b want 0", r_se); end
        run_pair(32'h7FFF_FFFF, 32'h8000_0000, 32'd1, lat, r_ll2, r_idx, r_fd, r_de, r_se, r_rdy, r_vld);
        n_cmp++; if (r_ll2 !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sat_pos_ll2: got %h want 7fffffff", r_ll2); end
        n_cmp++; if ({r_de, r_se} !== 2'b01) begin n_fail++; $display("FAIL sat_pos_flags: got %b want 01", {r_de, r_se}); end
        n_cmp++; if (lat !== 33)           begin n_fail++; $display("FAIL sat_pos_latency: got %0d want 33", lat); end
        run_pair(32'h8000_0000, 32'h7FFF_FFFF, 32'd1, lat, r_ll2, r_idx, r_fd, r_de, r_se, r_rdy, r_vld);
        n_cmp++; if (r_ll2 !== 32'h8000_0000) begin n_fail++; $display("FAIL sat_neg_ll2: got %h want 80000000", r_ll2); end
    endtask

    task automatic test_reset_mid_div();
        logic seen;
        in_valid = 1'b1; LLNEW = 32'd30; LL1 = 32'd10; alpha = 32'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL mid_rst_ready_valid: got %b want 10", {in_ready, out_valid}); end
        n_cmp++; if (coeff_index !== 12'd0) begin n_fail++; $display("FAIL mid_rst_idx: got %0d want 0", coeff_index); end
        n_cmp++; if (sat_err !== 1'b0)     begin n_fail++; $display("FAIL mid_rst_sat_err: got %b want 0", sat_err); end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0)        begin n_fail++; $display("FAIL mid_rst_stray_valid: got %b want 0", seen); end
        run_pair(32'd30, 32'd10, 32'd2, lat, r_ll2, r_idx, r_fd, r_de, r_se, r_rdy, r_vld);
        n_cmp++; if (r_ll2 !== 32'd10)     begin n_fail++; $display("FAIL mid_rst_next_ll2: got %h want 0000000a", r_ll2); end
        n_cmp++; if (lat !== 33)           begin n_fail++; $display("FAIL mid_rst_next_latency: got %0d want 33", lat); end
        n_cmp++; if (r_idx !== 12'd0)      begin n_fail++; $display("FAIL mid_rst_next_idx: got %0d want 0", r_idx); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_backpressure();
        test_frame_wrap();
        test_div_zero();
        test_saturation();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
